// File: rtl/pending_encoder.sv
// Sequential N:1 encoder: captures request pulses into a pending register and
// hands them out one binary index per cycle, lowest first, over valid/ready.
module pending_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] out,
  output logic [N-1:0] pending,
  output logic         busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_q, out_d;
  logic [N-1:0] reqMasked;
  logic [N-1:0] clrMask;
  logic [W-1:0] sel;
  logic         load;

  assign reqMasked = ena ? req : '0;
  assign load      = (|pending_q) & ((state_q == IDLE) | ready);

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = W'(i);
    end
  end

  // Clearing the loaded bit before OR-ing new requests lets a same-cycle
  // re-request of that bit survive and be emitted again later.
  assign clrMask   = load ? (ONE << sel) : '0;
  assign pending_d = (pending_q & ~clrMask) | reqMasked;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = HOLD;
          out_d   = sel;
        end
      end
      HOLD: begin
        if (ready && load) begin
          out_d = sel;
        end else if (ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign valid   = (state_q == HOLD);
  assign out     = out_q;
  assign pending = pending_q;
  assign busy    = (|pending_q) | valid;

endmodule
